updown_count_sched: RTL and testbench

- Two-requester scheduler that shares one external 8-bit up/down counter.
- Each requester issues commands over a valid/ready handshake: UP n steps, DOWN n steps, LOAD value, or CLEAR.
- A round-robin arbiter grants one command at a time. An FSM then drives the counter's enable, direction and load controls.
- The block sits between control logic and the counter. It reports completion and wrap-around for each command.

---
 rtl/updown_sched_pkg.sv | 27 ++
 rtl/updown_count_sched_rr_arbiter2.sv | 45 ++++
 rtl/updown_count_sched.sv | 191 +++++++++++++++++++
 tb/tb_updown_count_sched.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/updown_sched_pkg.sv
// Shared definitions for the two-requester up/down counter scheduler:
// opcode and FSM state encodings plus default widths.
package updown_sched_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_STEP_W = 8;

  typedef enum logic [1:0] {
    OP_UP    = 2'b00,
    OP_DOWN  = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_LOAD = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // True for the opcodes that step the counter rather than load it.
  function automatic logic is_step_op(input op_e op);
    return (op == OP_UP) || (op == OP_DOWN);
  endfunction

endpackage

// File: rtl/updown_count_sched_rr_arbiter2.sv
// Two-way round-robin arbiter. The pointer remembers which requester was
// served last; on a tie the other one wins. After reset requester 0 wins.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  // 1 = requester 1 was served last, so requester 0 is favoured next.
  logic last_q;
  logic last_d;

  // One-hot grant from the pending requests and the last-served pointer.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  // Pointer moves only when a grant is actually taken.
  always_comb begin
    last_d = last_q;
    if (advance_i) begin
      last_d = gnt_o[1];
    end else begin
      last_d = last_q;
    end
  end

  // Last-served pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/updown_count_sched.sv
// Scheduler that accepts UP/DOWN/LOAD/CLEAR commands from two requesters,
// arbitrates round-robin, and drives an external up/down counter. Reports a
// one-cycle done pulse per command with a sticky wrap flag.
module updown_count_sched
  import updown_sched_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [3:0]         req_op,
  input  logic [2*WIDTH-1:0] req_arg,
  input  logic [WIDTH-1:0]   cnt_value,
  output logic               cnt_en,
  output logic               cnt_up,
  output logic               cnt_load,
  output logic [WIDTH-1:0]   cnt_load_val,
  output logic               busy,
  output logic               owner,
  output logic               done,
  output logic               done_wrap
);

  state_e              state_q;
  logic                armed_q;      // low until the first clock after reset
  logic [STEP_W-1:0]   rem_q;        // steps still to issue in RUN
  logic                wrap_q;       // sticky wrap for the current command

  logic                cnt_en_q;
  logic                cnt_up_q;
  logic                cnt_load_q;
  logic [WIDTH-1:0]    cnt_load_val_q;
  logic                busy_q;
  logic                owner_q;
  logic                done_q;
  logic                done_wrap_q;

  logic [1:0]          gnt_d;
  logic                accept_d;
  logic                acc_idx_d;
  op_e                 acc_op_d;
  logic [WIDTH-1:0]    acc_arg_d;
  logic [STEP_W-1:0]   acc_step_d;
  logic                wrap_hit_d;
  logic                wrap_acc_d;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req_valid),
    .advance_i (accept_d),
    .gnt_o     (gnt_d)
  );

  // Ready only in IDLE and only once the block has come out of reset.
  always_comb begin
    req_ready = 2'b00;
    if ((state_q == ST_IDLE) && armed_q) begin
      req_ready = gnt_d;
    end else begin
      req_ready = 2'b00;
    end
    accept_d = |req_ready;
  end

  // Select opcode and argument of the granted requester.
  always_comb begin
    acc_idx_d = gnt_d[1];
    acc_op_d  = OP_UP;
    acc_arg_d = '0;
    if (acc_idx_d) begin
      acc_op_d  = op_e'(req_op[3:2]);
      acc_arg_d = req_arg[2*WIDTH-1:WIDTH];
    end else begin
      acc_op_d  = op_e'(req_op[1:0]);
      acc_arg_d = req_arg[WIDTH-1:0];
    end
    acc_step_d = acc_arg_d[STEP_W-1:0];
  end

  // Wrap happens when a step is taken from the extreme value in its direction.
  always_comb begin
    wrap_hit_d = 1'b0;
    if ((state_q == ST_RUN) && cnt_en_q) begin
      wrap_hit_d = (cnt_up_q  && (cnt_value == {WIDTH{1'b1}})) ||
                   (!cnt_up_q && (cnt_value == {WIDTH{1'b0}}));
    end else begin
      wrap_hit_d = 1'b0;
    end
    wrap_acc_d = wrap_q | wrap_hit_d;
  end

  // Command FSM with all counter controls and status outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      armed_q        <= 1'b0;
      rem_q          <= '0;
      wrap_q         <= 1'b0;
      cnt_en_q       <= 1'b0;
      cnt_up_q       <= 1'b0;
      cnt_load_q     <= 1'b0;
      cnt_load_val_q <= '0;
      busy_q         <= 1'b0;
      owner_q        <= 1'b0;
      done_q         <= 1'b0;
      done_wrap_q    <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            owner_q     <= acc_idx_d;
            wrap_q      <= 1'b0;
            busy_q      <= 1'b1;
            if (is_step_op(acc_op_d)) begin
              if (acc_step_d == '0) begin
                state_q     <= ST_DONE;
                done_q      <= 1'b1;
                done_wrap_q <= 1'b0;
              end else begin
                state_q  <= ST_RUN;
                rem_q    <= acc_step_d;
                cnt_en_q <= 1'b1;
                cnt_up_q <= (acc_op_d == OP_UP);
              end
            end else begin
              state_q    <= ST_LOAD;
              cnt_load_q <= 1'b1;
              if (acc_op_d == OP_LOAD) begin
                cnt_load_val_q <= acc_arg_d;
              end else begin
                cnt_load_val_q <= '0;
              end
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          wrap_q <= wrap_acc_d;
          if (rem_q == STEP_W'(1)) begin
            state_q     <= ST_DONE;
            cnt_en_q    <= 1'b0;
            cnt_up_q    <= 1'b0;
            rem_q       <= '0;
            done_q      <= 1'b1;
            done_wrap_q <= wrap_acc_d;
          end else begin
            rem_q <= rem_q - STEP_W'(1);
          end
        end
        ST_LOAD: begin
          state_q        <= ST_DONE;
          cnt_load_q     <= 1'b0;
          cnt_load_val_q <= '0;
          done_q         <= 1'b1;
          done_wrap_q    <= 1'b0;
        end
        ST_DONE: begin
          state_q     <= ST_IDLE;
          done_q      <= 1'b0;
          done_wrap_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q        <= ST_IDLE;
          cnt_en_q       <= 1'b0;
          cnt_load_q     <= 1'b0;
          cnt_load_val_q <= '0;
          done_q         <= 1'b0;
          done_wrap_q    <= 1'b0;
          busy_q         <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_en       = cnt_en_q;
  assign cnt_up       = cnt_up_q;
  assign cnt_load     = cnt_load_q;
  assign cnt_load_val = cnt_load_val_q;
  assign busy         = busy_q;
  assign owner        = owner_q;
  assign done         = done_q;
  assign done_wrap    = done_wrap_q;

endmodule

// File: tb/tb_updown_count_sched.sv
// Self-checking bench for updown_count_sched. Models the external counter
// and predicts each command's outcome from start value, opcode and argument.
module tb_updown_count_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_arg;
  logic [7:0]  cnt_value;
  logic        cnt_en, cnt_up, cnt_load;
  logic [7:0]  cnt_load_val;
  logic        busy, owner, done, done_wrap;

  int checks = 0;
  int failures = 0;

  updown_count_sched dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_arg      (req_arg),
    .cnt_value    (cnt_value),
    .cnt_en       (cnt_en),
    .cnt_up       (cnt_up),
    .cnt_load     (cnt_load),
    .cnt_load_val (cnt_load_val),
    .busy         (busy),
    .owner        (owner),
    .done         (done),
    .done_wrap    (done_wrap)
  );

  always #5 clk = ~clk;

  // External counter model
  logic [7:0] ctr;
  logic       set_en;
  logic [7:0] set_val;
  always @(posedge clk) begin
    if (set_en) ctr <= set_val;
    else if (cnt_en) ctr <= cnt_up ? ctr + 8'd1 : ctr - 8'd1;
    else if (cnt_load) ctr <= cnt_load_val;
  end
  assign cnt_value = ctr;

  // Observations of one command
  logic       obs_got;
  int         obs_done_at, obs_en, obs_up, obs_load, obs_bad_excl, obs_bad_rdy;
  logic [7:0] obs_lval;
  logic       obs_wrap, obs_owner, obs_done_after;
  logic       last_served;  // round-robin model

  task automatic set_ctr(input logic [7:0] v);
    set_en = 1'b1; set_val = v;
    @(negedge clk);
    set_en = 1'b0;
  endtask

  // Issue one command from requester r and record what the DUT does.
  task automatic do_cmd(input int r, input logic [1:0] op, input logic [7:0] arg);
    obs_got = 1'b0; obs_done_at = -1; obs_en = 0; obs_up = 0; obs_load = 0;
    obs_bad_excl = 0; obs_bad_rdy = 0; obs_lval = 8'd0; obs_wrap = 1'b0;
    obs_owner = 1'b0; obs_done_after = 1'b0;
    if (r == 0) begin req_op[1:0] = op; req_arg[7:0] = arg; end
    else begin req_op[3:2] = op; req_arg[15:8] = arg; end
    req_valid[r] = 1'b1;
    for (int w = 0; w < 20; w++) begin
      #1;
      if (req_ready[r]) begin obs_got = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    req_valid[r] = 1'b0;
    if (obs_got) begin
      last_served = r[0];
      for (int k = 1; k < 600; k++) begin
        if (cnt_en) begin obs_en++; if (cnt_up) obs_up++; end
        if (cnt_load) begin obs_load++; obs_lval = cnt_load_val; end
        if (cnt_en && cnt_load) obs_bad_excl++;
        if (req_ready != 2'b00) obs_bad_rdy++;
        if (done) begin
          obs_done_at = k; obs_wrap = done_wrap; obs_owner = owner;
          @(negedge clk);
          obs_done_after = done;
          break;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; req_valid = 2'b11; req_op = 4'b0000; req_arg = 16'h0101;
    set_en = 1'b1; set_val = 8'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, cnt_en, cnt_up, cnt_load, cnt_load_val, busy, owner, done, done_wrap} !== 17'd0) begin
      failures++;
      $display("FAIL reset_outputs: got ready=%b en=%b up=%b ld=%b lv=%h busy=%b own=%b done=%b wrap=%b, want all 0",
               req_ready, cnt_en, cnt_up, cnt_load, cnt_load_val, busy, owner, done, done_wrap);
    end
    req_valid = 2'b00; reset = 1'b1; set_en = 1'b0;
    last_served = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_up_basic;
    set_ctr(8'd10);
    do_cmd(0, 2'b00, 8'd5);
    checks++; if (obs_got !== 1'b1) begin failures++; $display("FAIL up_ready: got %b want 1", obs_got); end
    checks++; if (obs_en != 5) begin failures++; $display("FAIL up_en_cycles: got %0d want 5", obs_en); end
    checks++; if (obs_up != 5) begin failures++; $display("FAIL up_dir: got %0d up cycles want 5", obs_up); end
    checks++; if (ctr !== 8'd15) begin failures++; $display("FAIL up_final: got %0d want 15", ctr); end
    checks++; if (obs_done_at != 6) begin failures++; $display("FAIL up_latency: got %0d want 6", obs_done_at); end
    checks++; if ({obs_wrap, obs_owner} !== 2'b00) begin failures++; $display("FAIL up_wrap_owner: got %b want 00", {obs_wrap, obs_owner}); end
    checks++; if (obs_done_after !== 1'b0 || obs_bad_rdy != 0) begin failures++; $display("FAIL up_pulse: done_after=%b ready_busy=%0d want 0/0", obs_done_after, obs_bad_rdy); end
  endtask

  task automatic test_alternate;
    int n, overlap;
    logic exp_idx;
    logic [2:0] seq;
    reset = 1'b0; @(negedge clk); reset = 1'b1; @(negedge clk);
    last_served = 1'b1;
    n = 0; overlap = 0; seq = 3'b000;
    req_op = 4'b0000; req_arg = {8'd2, 8'd2}; req_valid = 2'b11;
    for (int c = 0; c < 60 && n < 3; c++) begin
      #1;
      if (req_ready == 2'b11) overlap++;
      else if (req_ready != 2'b00) begin
        exp_idx = ~last_served;
        checks++;
        if (req_ready[1] !== exp_idx) begin
          failures++; $display("FAIL rr_grant%0d: got req%0d want req%0d", n, req_ready[1], exp_idx);
        end
        seq[n] = req_ready[1];
        last_served = req_ready[1];
        n++;
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    checks++; if (n != 3 || overlap != 0) begin failures++; $display("FAIL rr_count: grants=%0d overlap=%0d want 3/0", n, overlap); end
    checks++; if (seq !== 3'b010) begin failures++; $display("FAIL rr_sequence: got %b want 010 (req0,req1,req0)", seq); end
    for (int w = 0; w < 20 && busy; w++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_down_wrap;
    set_ctr(8'd1);
    do_cmd(1, 2'b01, 8'd3);
    checks++; if (obs_en != 3 || obs_up != 0) begin failures++; $display("FAIL down_en: got en=%0d up=%0d want 3/0", obs_en, obs_up); end
    checks++; if (ctr !== 8'd254) begin failures++; $display("FAIL down_final: got %0d want 254", ctr); end
    checks++; if (obs_wrap !== 1'b1) begin failures++; $display("FAIL down_wrap: got %b want 1", obs_wrap); end
    checks++; if (obs_owner !== 1'b1 || obs_done_at != 4) begin failures++; $display("FAIL down_owner_lat: owner=%b lat=%0d want 1/4", obs_owner, obs_done_at); end
  endtask

  task automatic test_load_clear;
    set_ctr(8'd7);
    do_cmd(0, 2'b10, 8'hA5);
    checks++; if (obs_load != 1 || obs_lval !== 8'hA5) begin failures++; $display("FAIL load_pulse: cycles=%0d val=%h want 1/a5", obs_load, obs_lval); end
    checks++; if (obs_en != 0 || obs_wrap !== 1'b0 || obs_done_at != 2) begin failures++; $display("FAIL load_misc: en=%0d wrap=%b lat=%0d want 0/0/2", obs_en, obs_wrap, obs_done_at); end
    checks++; if (ctr !== 8'hA5) begin failures++; $display("FAIL load_final: got %h want a5", ctr); end
    set_ctr(8'hFF);
    do_cmd(0, 2'b11, 8'h3C);
    checks++; if (obs_load != 1 || obs_lval !== 8'h00) begin failures++; $display("FAIL clear_pulse: cycles=%0d val=%h want 1/00", obs_load, obs_lval); end
    checks++; if (obs_en != 0 || obs_wrap !== 1'b0 || ctr !== 8'h00) begin failures++; $display("FAIL clear_misc: en=%0d wrap=%b ctr=%h want 0/0/00", obs_en, obs_wrap, ctr); end
  endtask

  task automatic test_zero_and_max;
    set_ctr(8'd40);
    do_cmd(1, 2'b00, 8'd0);
    checks++; if (obs_en != 0 || obs_done_at != 1) begin failures++; $display("FAIL zero_arg: en=%0d lat=%0d want 0/1", obs_en, obs_done_at); end
    checks++; if (ctr !== 8'd40 || obs_owner !== 1'b1) begin failures++; $display("FAIL zero_state: ctr=%0d owner=%b want 40/1", ctr, obs_owner); end
    set_ctr(8'd3);
    do_cmd(0, 2'b00, 8'd255);
    checks++; if (obs_en != 255 || obs_done_at != 256) begin failures++; $display("FAIL max_steps: en=%0d lat=%0d want 255/256", obs_en, obs_done_at); end
    checks++; if (ctr !== 8'd2 || obs_wrap !== 1'b1) begin failures++; $display("FAIL max_final: ctr=%0d wrap=%b want 2/1", ctr, obs_wrap); end
  endtask

  task automatic test_random;
    int r, s, n, exp_final, exp_en, exp_lat, exp_load;
    logic [1:0] op;
    logic [7:0] arg, exp_lval;
    logic exp_wrap;
    for (int it = 0; it < 16; it++) begin
      r = $urandom_range(0, 1);
      op = 2'($urandom_range(0, 3));
      n = $urandom_range(0, 12);
      arg = (op[1]) ? 8'($urandom_range(0, 255)) : 8'(n);
      case ($urandom_range(0, 4))
        0: s = 0;
        1: s = 255;
        2: s = $urandom_range(0, 3);
        3: s = $urandom_range(250, 255);
        default: s = $urandom_range(0, 255);
      endcase
      if (op == 2'b00) begin
        exp_en = n; exp_final = (s + n) % 256; exp_wrap = (s + n > 255);
        exp_lat = (n == 0) ? 1 : n + 1; exp_load = 0; exp_lval = 8'd0;
      end else if (op == 2'b01) begin
        exp_en = n; exp_final = (s - n + 256) % 256; exp_wrap = (n > s);
        exp_lat = (n == 0) ? 1 : n + 1; exp_load = 0; exp_lval = 8'd0;
      end else begin
        exp_en = 0; exp_wrap = 1'b0; exp_lat = 2; exp_load = 1;
        exp_lval = (op == 2'b10) ? arg : 8'd0; exp_final = exp_lval;
      end
      set_ctr(8'(s));
      do_cmd(r, op, arg);
      checks++; if (obs_done_at != exp_lat) begin failures++; $display("FAIL rnd%0d_latency: op=%0d arg=%0d got %0d want %0d", it, op, arg, obs_done_at, exp_lat); end
      checks++; if (obs_en != exp_en || obs_up != ((op == 2'b00) ? exp_en : 0)) begin failures++; $display("FAIL rnd%0d_steps: en=%0d up=%0d want %0d", it, obs_en, obs_up, exp_en); end
      checks++; if (ctr !== 8'(exp_final)) begin failures++; $display("FAIL rnd%0d_final: start=%0d got %0d want %0d", it, s, ctr, exp_final); end
      checks++; if (obs_wrap !== exp_wrap) begin failures++; $display("FAIL rnd%0d_wrap: op=%0d start=%0d n=%0d got %b want %b", it, op, s, n, obs_wrap, exp_wrap); end
      checks++; if (obs_load != exp_load || obs_lval !== exp_lval) begin failures++; $display("FAIL rnd%0d_load: cycles=%0d val=%h want %0d/%h", it, obs_load, obs_lval, exp_load, exp_lval); end
      checks++; if (obs_owner !== r[0] || obs_bad_excl != 0 || obs_bad_rdy != 0 || obs_done_after !== 1'b0) begin
        failures++; $display("FAIL rnd%0d_misc: owner=%b excl=%0d rdy=%0d done_after=%b want %0d/0/0/0", it, obs_owner, obs_bad_excl, obs_bad_rdy, obs_done_after, r);
      end
    end
  endtask

  task automatic test_reset_mid_run;
    logic got;
    int done_seen;
    set_ctr(8'd0);
    req_op[1:0] = 2'b00; req_arg[7:0] = 8'd10; req_valid[0] = 1'b1;
    got = 1'b0;
    for (int w = 0; w < 20; w++) begin #1; if (req_ready[0]) begin got = 1'b1; break; end @(negedge clk); end
    @(negedge clk); req_valid[0] = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (got !== 1'b1 || cnt_en !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL midrst_running: got=%b en=%b busy=%b want 1/1/1", got, cnt_en, busy); end
    reset = 1'b0; req_valid = 2'b11;
    #1;
    checks++; if ({cnt_en, busy, done} !== 3'b000) begin failures++; $display("FAIL midrst_async: en=%b busy=%b done=%b want 000", cnt_en, busy, done); end
    done_seen = 0;
    repeat (3) begin @(negedge clk); if (done || req_ready != 2'b00) done_seen++; end
    checks++; if (done_seen != 0) begin failures++; $display("FAIL midrst_quiet: %0d cycles with done/ready want 0", done_seen); end
    reset = 1'b1; req_op = 4'b0000; req_arg = 16'h0000;
    got = 1'b0;
    for (int w = 0; w < 20; w++) begin #1; if (req_ready != 2'b00) begin got = 1'b1; break; end @(negedge clk); end
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL midrst_grant: got ready=%b want 01", req_ready); end
    @(negedge clk); req_valid = 2'b00;
    for (int w = 0; w < 20 && busy; w++) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_up_basic;
    test_alternate;
    test_down_wrap;
    test_load_clear;
    test_zero_and_max;
    test_random;
    test_reset_mid_run;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
